// File: rtl/hilo_muldiv_ctrl_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer.
// Holds the operation codes presented by EX and the sequencer state encoding.
package hilo_muldiv_ctrl_pkg;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SIGN = 2'd2,
    WB   = 2'd3
  } state_t;

endpackage

// File: rtl/muldiv_iter.sv
// One iteration of the unsigned multiply / restoring-divide loop.
// Multiply: {hi,lo} holds {partial product, remaining multiplier bits}; b is the multiplicand.
// Divide:   hi is the partial remainder, lo the dividend shifting into quotient; b is the divisor.
// Ports:
//   is_div   select divide step (1) or multiply step (0)
//   hi, lo   current accumulator pair
//   b        multiplicand / divisor magnitude
//   hi_next, lo_next  accumulator pair after this step
module muldiv_iter #(
  parameter int unsigned W = 32
) (
  input  logic         is_div,
  input  logic [W-1:0] hi,
  input  logic [W-1:0] lo,
  input  logic [W-1:0] b,
  output logic [W-1:0] hi_next,
  output logic [W-1:0] lo_next
);

  logic [W:0] sum;
  logic [W:0] shifted;
  logic [W:0] diff;

  always_comb begin
    sum     = {1'b0, hi} + (lo[0] ? {1'b0, b} : '0);
    shifted = {hi, lo[W-1]};
    diff    = shifted - {1'b0, b};
    if (is_div) begin
      // The partial remainder stays below the divisor, so diff[W] is a clean borrow flag.
      if (!diff[W]) begin
        hi_next = diff[W-1:0];
        lo_next = {lo[W-2:0], 1'b1};
      end else begin
        hi_next = shifted[W-1:0];
        lo_next = {lo[W-2:0], 1'b0};
      end
    end else begin
      // Carry out of the add shifts into the top of the product.
      {hi_next, lo_next} = {sum, lo[W-1:1]};
    end
  end

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// Multi-cycle multiply/divide sequencer owning all HI/LO writes.
// MULT/MULTU/DIV/DIVU run 32 iterations on operand magnitudes, then a sign fix-up,
// then a one-cycle write. MTHI/MTLO write in the cycle after acceptance.
// Optional macro MULDIV_ZERO_SKIP_EN: multiply by zero and divide by zero skip the loop.
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   start, op       request and operation code (sampled only in IDLE)
//   opa, opb        rs / rt operands
//   cancel          flush; aborts any operation, gates the write in WB
//   hi_cur, lo_cur  current HI/LO, used to fill the untouched half on MTLO/MTHI
//   busy            high whenever not IDLE
//   hilo_we         one-cycle HI/LO write enable
//   hi_o, lo_o      HI/LO write data, held between writes
module hilo_muldiv_ctrl
  import hilo_muldiv_ctrl_pkg::*;
#(
  parameter int unsigned W     = 32,
  parameter int unsigned CNT_W = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [2:0]   op,
  input  logic [W-1:0] opa,
  input  logic [W-1:0] opb,
  input  logic         cancel,
  input  logic [W-1:0] hi_cur,
  input  logic [W-1:0] lo_cur,
  output logic         busy,
  output logic         hilo_we,
  output logic [W-1:0] hi_o,
  output logic [W-1:0] lo_o
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d, b_q, b_d;
  logic [W-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic             is_div_q, is_div_d, neg_a_q, neg_a_d, neg_b_q, neg_b_d;

  logic             is_arith, is_signed, is_div_op, div_zero, a_neg, b_neg;
  logic [W-1:0]     a_mag, b_mag, iter_hi, iter_lo;
  logic [2*W-1:0]   prod_fix;

  assign is_arith  = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  assign is_signed = (op == OP_MULT) || (op == OP_DIV);
  assign is_div_op = (op == OP_DIV) || (op == OP_DIVU);
  assign div_zero  = is_div_op && (opb == '0);
  // Divide by zero keeps the raw dividend: the loop then yields quotient all ones and
  // remainder equal to opa with no sign fix-up needed.
  assign a_neg     = is_signed && opa[W-1] && !div_zero;
  assign b_neg     = is_signed && opb[W-1] && !div_zero;
  assign a_mag     = a_neg ? -opa : opa;
  assign b_mag     = b_neg ? -opb : opb;
  assign prod_fix  = (neg_a_q ^ neg_b_q) ? -{acc_hi_q, acc_lo_q} : {acc_hi_q, acc_lo_q};

  muldiv_iter #(
    .W(W)
  ) u_iter (
    .is_div  (is_div_q),
    .hi      (acc_hi_q),
    .lo      (acc_lo_q),
    .b       (b_q),
    .hi_next (iter_hi),
    .lo_next (iter_lo)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    b_d      = b_q;
    is_div_d = is_div_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    unique case (state_q)
      IDLE: begin
        if (start && !cancel) begin
          if (is_arith) begin
            state_d  = CALC;
            cnt_d    = '0;
            is_div_d = is_div_op;
            neg_a_d  = a_neg;
            neg_b_d  = b_neg;
            acc_hi_d = '0;
            // Multiply shifts the multiplier out of lo; divide shifts the dividend out.
            acc_lo_d = is_div_op ? a_mag : b_mag;
            b_d      = is_div_op ? b_mag : a_mag;
`ifdef MULDIV_ZERO_SKIP_EN
            if (!is_div_op && ((opa == '0) || (opb == '0))) begin
              state_d = WB;
              hi_d    = '0;
              lo_d    = '0;
            end else if (div_zero) begin
              state_d = WB;
              hi_d    = opa;
              lo_d    = '1;
            end
`endif
          end else if (op == OP_MTHI) begin
            state_d = WB;
            hi_d    = opa;
            lo_d    = lo_cur;
          end else if (op == OP_MTLO) begin
            state_d = WB;
            hi_d    = hi_cur;
            lo_d    = opa;
          end
        end
      end
      CALC: begin
        acc_hi_d = iter_hi;
        acc_lo_d = iter_lo;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == '1) state_d = SIGN;
      end
      SIGN: begin
        state_d = WB;
        if (is_div_q) begin
          lo_d = (neg_a_q ^ neg_b_q) ? -acc_lo_q : acc_lo_q;
          hi_d = neg_a_q ? -acc_hi_q : acc_hi_q;
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
      end
      WB: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // A flush abandons the operation and leaves the output data untouched.
    if (cancel && (state_q != IDLE)) begin
      state_d = IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      b_q      <= '0;
      is_div_q <= 1'b0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      b_q      <= b_d;
      is_div_q <= is_div_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign busy    = (state_q != IDLE);
  assign hilo_we = (state_q == WB) && !cancel;
  assign hi_o    = hi_q;
  assign lo_o    = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Directed bench for hilo_muldiv_ctrl: a table of single operations with hand-computed
// results and latencies, plus hand-written sequences for cancel, reset and start-while-busy.
module tb_hilo_muldiv_ctrl;
  import hilo_muldiv_ctrl_pkg::*;

`ifdef MULDIV_ZERO_SKIP_EN
  localparam int ZL = 1;
`else
  localparam int ZL = 34;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = '0;
  logic [31:0] opa = '0, opb = '0, hi_cur = '0, lo_cur = '0;
  logic        cancel = 1'b0;
  logic        busy, hilo_we;
  logic [31:0] hi_o, lo_o;

  int checks = 0;
  int failures = 0;

  hilo_muldiv_ctrl #(
    .W(32),
    .CNT_W(5)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .opa     (opa),
    .opb     (opb),
    .cancel  (cancel),
    .hi_cur  (hi_cur),
    .lo_cur  (lo_cur),
    .busy    (busy),
    .hilo_we (hilo_we),
    .hi_o    (hi_o),
    .lo_o    (lo_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a, b, hc, lc;
    int          lat;
    logic [31:0] hi, lo;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation in the current cycle (cycle 0) and observe cycles 1..38.
  task automatic run_op(input vec_t v);
    int          we_cnt;
    int          we_cyc;
    logic        busy_ok;
    logic [31:0] gh, gl;
    we_cnt = 0; we_cyc = -1; busy_ok = 1'b1; gh = '0; gl = '0;
    op = v.op; opa = v.a; opb = v.b; hi_cur = v.hc; lo_cur = v.lc; start = 1'b1;
    for (int k = 1; k <= 38; k++) begin
      tick();
      start = 1'b0;
      #1;
      if (hilo_we) begin
        we_cnt++;
        if (we_cyc < 0) begin
          we_cyc = k; gh = hi_o; gl = lo_o;
        end
      end
      if (k <= v.lat && !busy) busy_ok = 1'b0;
      if (k == v.lat + 1 && busy) busy_ok = 1'b0;
    end
    check({v.name, " we_cycle"}, 64'(we_cyc), 64'(v.lat));
    check({v.name, " we_count"}, 64'(we_cnt), 64'd1);
    check({v.name, " busy"}, 64'(busy_ok), 64'd1);
    check({v.name, " hi"}, 64'(gh), 64'(v.hi));
    check({v.name, " lo"}, 64'(gl), 64'(v.lo));
  endtask

  initial begin
    int          we_cnt;
    int          we_cyc;
    logic [31:0] gh, gl;

    vecs[0]  = '{"multu_ff",   OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 34, 32'hFFFFFFFE, 32'h1};
    vecs[1]  = '{"mult_m3x5",  OP_MULT,  32'hFFFFFFFD, 32'd5, 0, 0, 34, 32'hFFFFFFFF, 32'hFFFFFFF1};
    vecs[2]  = '{"div_m7d2",   OP_DIV,   32'hFFFFFFF9, 32'd2, 0, 0, 34, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3]  = '{"divu_7d0",   OP_DIVU,  32'd7, 32'd0, 0, 0, ZL, 32'd7, 32'hFFFFFFFF};
    vecs[4]  = '{"mthi",       OP_MTHI,  32'h12345678, 0, 32'h0, 32'hAAAA0000, 1,
                 32'h12345678, 32'hAAAA0000};
    vecs[5]  = '{"div_minneg", OP_DIV,   32'h80000000, 32'hFFFFFFFF, 0, 0, 34, 32'h0, 32'h80000000};
    vecs[6]  = '{"mult_minsq", OP_MULT,  32'h80000000, 32'h80000000, 0, 0, 34, 32'h40000000, 32'h0};
    vecs[7]  = '{"div_100dm7", OP_DIV,   32'd100, 32'hFFFFFFF9, 0, 0, 34, 32'd2, 32'hFFFFFFF2};
    vecs[8]  = '{"multu_zero", OP_MULTU, 32'd0, 32'h12345, 0, 0, ZL, 32'h0, 32'h0};
    vecs[9]  = '{"div_m7d0",   OP_DIV,   32'hFFFFFFF9, 32'd0, 0, 0, ZL, 32'hFFFFFFF9, 32'hFFFFFFFF};
    vecs[10] = '{"mult_7xm1",  OP_MULT,  32'd7, 32'hFFFFFFFF, 0, 0, 34, 32'hFFFFFFFF, 32'hFFFFFFF9};
    vecs[11] = '{"divu_big",   OP_DIVU,  32'hFFFFFFFF, 32'd10, 0, 0, 34, 32'd5, 32'h19999999};
    vecs[12] = '{"multu_2p32", OP_MULTU, 32'h10000, 32'h10000, 0, 0, 34, 32'h1, 32'h0};
    vecs[13] = '{"mtlo",       OP_MTLO,  32'h0BADF00D, 0, 32'h55550000, 32'h0, 1,
                 32'h55550000, 32'h0BADF00D};

    // Reset state
    tick();
    tick();
    check("reset busy", 64'(busy), 64'd0);
    check("reset we", 64'(hilo_we), 64'd0);
    check("reset hi", 64'(hi_o), 64'd0);
    check("reset lo", 64'(lo_o), 64'd0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 14; i++) run_op(vecs[i]);

    // Reset pulsed in cycle 20 of a MULT; outputs hold nonzero MTLO data beforehand.
    op = OP_MULT; opa = 32'd5; opb = 32'd6; start = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      start = 1'b0;
    end
    reset = 1'b1;
    #1;
    check("midreset busy", 64'(busy), 64'd0);
    check("midreset we", 64'(hilo_we), 64'd0);
    check("midreset hi", 64'(hi_o), 64'd0);
    check("midreset lo", 64'(lo_o), 64'd0);
    tick();
    reset = 1'b0;
    we_cnt = 0;
    for (int k = 0; k < 36; k++) begin
      tick();
      if (hilo_we) we_cnt++;
    end
    check("midreset no write", 64'(we_cnt), 64'd0);

    // DIVU cancelled in cycle 10, MULTU 3x4 started in cycle 11 writes in cycle 45.
    op = OP_DIVU; opa = 32'd100; opb = 32'd7; start = 1'b1;
    we_cnt = 0; we_cyc = -1; gh = '0; gl = '0;
    for (int k = 1; k <= 50; k++) begin
      tick();
      start = 1'b0;
      if (k == 10) cancel = 1'b1;
      if (k == 11) begin
        cancel = 1'b0;
        check("cancel busy c11", 64'(busy), 64'd0);
        op = OP_MULTU; opa = 32'd3; opb = 32'd4; start = 1'b1;
      end
      #1;
      if (hilo_we) begin
        we_cnt++;
        if (we_cyc < 0) begin
          we_cyc = k; gh = hi_o; gl = lo_o;
        end
      end
    end
    check("cancel then multu we_cycle", 64'(we_cyc), 64'd45);
    check("cancel then multu we_count", 64'(we_cnt), 64'd1);
    check("cancel then multu hi", 64'(gh), 64'd0);
    check("cancel then multu lo", 64'(gl), 64'd12);

    // start together with cancel in IDLE is not accepted.
    op = OP_MTHI; opa = 32'hCAFE; start = 1'b1; cancel = 1'b1;
    tick();
    start = 1'b0; cancel = 1'b0;
    #1;
    check("start+cancel busy", 64'(busy), 64'd0);
    check("start+cancel we", 64'(hilo_we), 64'd0);

    // Unknown op code is ignored.
    op = 3'd6; opa = 32'h1; start = 1'b1;
    tick();
    start = 1'b0;
    #1;
    check("unknown op busy", 64'(busy), 64'd0);
    check("unknown op we", 64'(hilo_we), 64'd0);

    // cancel during WB gates the write enable in the same cycle.
    op = OP_MTHI; opa = 32'h1; lo_cur = 32'h2; start = 1'b1;
    tick();
    start = 1'b0; cancel = 1'b1;
    #1;
    check("wb cancel we", 64'(hilo_we), 64'd0);
    tick();
    cancel = 1'b0;
    #1;
    check("wb cancel busy after", 64'(busy), 64'd0);

    // start while busy is ignored: only the MULTU result is written.
    op = OP_MULTU; opa = 32'd3; opb = 32'd4; start = 1'b1;
    we_cnt = 0; we_cyc = -1; gh = '0; gl = '0;
    for (int k = 1; k <= 38; k++) begin
      tick();
      start = 1'b0;
      if (k == 5) begin
        op = OP_MTHI; opa = 32'hDEAD; start = 1'b1;
      end
      #1;
      if (hilo_we) begin
        we_cnt++;
        if (we_cyc < 0) begin
          we_cyc = k; gh = hi_o; gl = lo_o;
        end
      end
    end
    check("busy start we_cycle", 64'(we_cyc), 64'd34);
    check("busy start we_count", 64'(we_cnt), 64'd1);
    check("busy start hi", 64'(gh), 64'd0);
    check("busy start lo", 64'(gl), 64'd12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
